// File: rtl/or1k_marocchino_dest_ordq.sv
// In-order destination queue: hands out write-back IDs at DECODE and retires them oldest-first at WriteBack.
// Optional protocol checking is built when OR1K_MAROCCHINO_ORDQ_CHECK_EN is defined.
module or1k_marocchino_dest_ordq #(
    parameter int OPTION_RF_ADDR_WIDTH = 5,
    parameter int DEST_EXTADR_WIDTH    = 3,
    parameter int ORDQ_DEPTH           = 4
) (
    input  logic                            cpu_clk,
    input  logic                            cpu_rst_n,
    input  logic                            padv_exec_i,
    input  logic                            padv_wrbk_i,
    input  logic                            pipeline_flush_i,
    input  logic                            dcod_rfd1_we_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] dcod_rfd1_adr_i,
    input  logic                            dcod_rfd2_we_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] dcod_rfd2_adr_i,
    output logic [DEST_EXTADR_WIDTH-1:0]    dcod_extadr_o,
    output logic                            ordq_full_o,
    output logic                            ordq_empty_o,
    output logic                            exec_valid_o,
    output logic [DEST_EXTADR_WIDTH-1:0]    exec_extadr_o,
    output logic                            exec_rfd1_we_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] exec_rfd1_adr_o,
    output logic                            exec_rfd2_we_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] exec_rfd2_adr_o,
    output logic                            ordq_err_o
);

    localparam int PTR_W = $clog2(ORDQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                            ent_rfd1_we  [ORDQ_DEPTH];
    logic [OPTION_RF_ADDR_WIDTH-1:0] ent_rfd1_adr [ORDQ_DEPTH];
    logic                            ent_rfd2_we  [ORDQ_DEPTH];
    logic [OPTION_RF_ADDR_WIDTH-1:0] ent_rfd2_adr [ORDQ_DEPTH];
    logic [DEST_EXTADR_WIDTH-1:0]    ent_extadr   [ORDQ_DEPTH];

    logic [PTR_W-1:0]             rd_ptr;
    logic [PTR_W-1:0]             wr_ptr;
    logic [CNT_W-1:0]             count;
    logic [DEST_EXTADR_WIDTH-1:0] id_cnt;

    logic full;
    logic empty;
    logic push_ok;
    logic pop_ok;

    assign full    = (count == CNT_W'(ORDQ_DEPTH));
    assign empty   = (count == '0);
    // A push into a full queue is dropped even when a pop frees a slot in the same cycle.
    assign push_ok = padv_exec_i & ~full;
    assign pop_ok  = padv_wrbk_i & ~empty;

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            id_cnt <= '0;
        end else if (pipeline_flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            id_cnt <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                id_cnt <= id_cnt + DEST_EXTADR_WIDTH'(1);
            end
            if (pop_ok)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok && !pop_ok)
                count <= count + CNT_W'(1);
            else if (!push_ok && pop_ok)
                count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            for (int i = 0; i < ORDQ_DEPTH; i++) begin
                ent_rfd1_we[i]  <= 1'b0;
                ent_rfd1_adr[i] <= '0;
                ent_rfd2_we[i]  <= 1'b0;
                ent_rfd2_adr[i] <= '0;
                ent_extadr[i]   <= '0;
            end
        end else if (push_ok && !pipeline_flush_i) begin
            ent_rfd1_we[wr_ptr]  <= dcod_rfd1_we_i;
            ent_rfd1_adr[wr_ptr] <= dcod_rfd1_adr_i;
            ent_rfd2_we[wr_ptr]  <= dcod_rfd2_we_i;
            ent_rfd2_adr[wr_ptr] <= dcod_rfd2_adr_i;
            ent_extadr[wr_ptr]   <= id_cnt;
        end
    end

    // All outputs below come from registered state only.
    assign dcod_extadr_o   = id_cnt;
    assign ordq_full_o     = full;
    assign ordq_empty_o    = empty;
    assign exec_valid_o    = ~empty;
    assign exec_extadr_o   = ent_extadr[rd_ptr];
    assign exec_rfd1_we_o  = ent_rfd1_we[rd_ptr] & ~empty;
    assign exec_rfd1_adr_o = ent_rfd1_adr[rd_ptr];
    assign exec_rfd2_we_o  = ent_rfd2_we[rd_ptr] & ~empty;
    assign exec_rfd2_adr_o = ent_rfd2_adr[rd_ptr];

`ifdef OR1K_MAROCCHINO_ORDQ_CHECK_EN
    logic err_r;

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n)
            err_r <= 1'b0;
        else if (pipeline_flush_i)
            err_r <= 1'b0;
        else if ((padv_exec_i & full & ~padv_wrbk_i) | (padv_wrbk_i & empty))
            err_r <= 1'b1;
    end

    assign ordq_err_o = err_r;
`else
    assign ordq_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_or1k_marocchino_dest_ordq.sv
// Bench for or1k_marocchino_dest_ordq: directed scenarios plus random traffic checked against a queue-based model.
module tb_or1k_marocchino_dest_ordq;

    localparam int AW    = 5;
    localparam int EW    = 3;
    localparam int DEPTH = 4;

    logic          cpu_clk = 1'b0;
    logic          cpu_rst_n;
    logic          padv_exec_i;
    logic          padv_wrbk_i;
    logic          pipeline_flush_i;
    logic          dcod_rfd1_we_i;
    logic [AW-1:0] dcod_rfd1_adr_i;
    logic          dcod_rfd2_we_i;
    logic [AW-1:0] dcod_rfd2_adr_i;
    logic [EW-1:0] dcod_extadr_o;
    logic          ordq_full_o;
    logic          ordq_empty_o;
    logic          exec_valid_o;
    logic [EW-1:0] exec_extadr_o;
    logic          exec_rfd1_we_o;
    logic [AW-1:0] exec_rfd1_adr_o;
    logic          exec_rfd2_we_o;
    logic [AW-1:0] exec_rfd2_adr_o;
    logic          ordq_err_o;

    or1k_marocchino_dest_ordq #(
        .OPTION_RF_ADDR_WIDTH (AW),
        .DEST_EXTADR_WIDTH    (EW),
        .ORDQ_DEPTH           (DEPTH)
    ) dut (
        .cpu_clk          (cpu_clk),
        .cpu_rst_n        (cpu_rst_n),
        .padv_exec_i      (padv_exec_i),
        .padv_wrbk_i      (padv_wrbk_i),
        .pipeline_flush_i (pipeline_flush_i),
        .dcod_rfd1_we_i   (dcod_rfd1_we_i),
        .dcod_rfd1_adr_i  (dcod_rfd1_adr_i),
        .dcod_rfd2_we_i   (dcod_rfd2_we_i),
        .dcod_rfd2_adr_i  (dcod_rfd2_adr_i),
        .dcod_extadr_o    (dcod_extadr_o),
        .ordq_full_o      (ordq_full_o),
        .ordq_empty_o     (ordq_empty_o),
        .exec_valid_o     (exec_valid_o),
        .exec_extadr_o    (exec_extadr_o),
        .exec_rfd1_we_o   (exec_rfd1_we_o),
        .exec_rfd1_adr_o  (exec_rfd1_adr_o),
        .exec_rfd2_we_o   (exec_rfd2_we_o),
        .exec_rfd2_adr_o  (exec_rfd2_adr_o),
        .ordq_err_o       (ordq_err_o)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        bit          w1;
        bit [AW-1:0] a1;
        bit          w2;
        bit [AW-1:0] a2;
        int          id;
    } ent_t;

    ent_t q[$];
    int   next_id;
    bit   m_err;
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef OR1K_MAROCCHINO_ORDQ_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        cmp({tag, ".dcod_extadr"}, 32'(dcod_extadr_o), 0);
        cmp({tag, ".exec_extadr"}, 32'(exec_extadr_o), 0);
        cmp({tag, ".empty"}, 32'(ordq_empty_o), 1);
        cmp({tag, ".full"}, 32'(ordq_full_o), 0);
        cmp({tag, ".valid"}, 32'(exec_valid_o), 0);
        cmp({tag, ".we1"}, 32'(exec_rfd1_we_o), 0);
        cmp({tag, ".adr1"}, 32'(exec_rfd1_adr_o), 0);
        cmp({tag, ".we2"}, 32'(exec_rfd2_we_o), 0);
        cmp({tag, ".adr2"}, 32'(exec_rfd2_adr_o), 0);
        cmp({tag, ".err"}, 32'(ordq_err_o), 0);
    endtask

    task automatic check_model(input string tag);
        bit v;
        v = (q.size() != 0);
        cmp({tag, ".dcod_extadr"}, 32'(dcod_extadr_o), 32'(next_id));
        cmp({tag, ".full"}, 32'(ordq_full_o), 32'(q.size() == DEPTH));
        cmp({tag, ".empty"}, 32'(ordq_empty_o), 32'(!v));
        cmp({tag, ".valid"}, 32'(exec_valid_o), 32'(v));
        cmp({tag, ".err"}, 32'(ordq_err_o), 32'(m_err));
        if (v) begin
            cmp({tag, ".exec_extadr"}, 32'(exec_extadr_o), 32'(q[0].id));
            cmp({tag, ".we1"}, 32'(exec_rfd1_we_o), 32'(q[0].w1));
            cmp({tag, ".adr1"}, 32'(exec_rfd1_adr_o), 32'(q[0].a1));
            cmp({tag, ".we2"}, 32'(exec_rfd2_we_o), 32'(q[0].w2));
            cmp({tag, ".adr2"}, 32'(exec_rfd2_adr_o), 32'(q[0].a2));
        end else begin
            cmp({tag, ".we1"}, 32'(exec_rfd1_we_o), 0);
            cmp({tag, ".we2"}, 32'(exec_rfd2_we_o), 0);
        end
    endtask

    // Called just after a falling edge: drive, check pre-edge state, clock, update the model.
    task automatic step(input string tag, input bit ex, input bit wb, input bit fl,
                        input bit w1, input bit [AW-1:0] a1, input bit w2, input bit [AW-1:0] a2);
        ent_t e;
        bit   is_full, is_empty;
        padv_exec_i      = ex;
        padv_wrbk_i      = wb;
        pipeline_flush_i = fl;
        dcod_rfd1_we_i   = w1;
        dcod_rfd1_adr_i  = a1;
        dcod_rfd2_we_i   = w2;
        dcod_rfd2_adr_i  = a2;
        check_model(tag);
        @(posedge cpu_clk);
        if (fl) begin
            q.delete();
            next_id = 0;
            m_err   = 1'b0;
        end else begin
            is_full  = (q.size() == DEPTH);
            is_empty = (q.size() == 0);
            if (CHECK_EN && ((ex && is_full && !wb) || (wb && is_empty)))
                m_err = 1'b1;
            if (wb && !is_empty)
                void'(q.pop_front());
            if (ex && !is_full) begin
                e.w1 = w1; e.a1 = a1; e.w2 = w2; e.a2 = a2; e.id = next_id;
                q.push_back(e);
                next_id = (next_id + 1) % (1 << EW);
            end
        end
        @(negedge cpu_clk);
    endtask

    task automatic model_reset();
        q.delete();
        next_id = 0;
        m_err   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cpu_rst_n        = 1'b0;
        padv_exec_i      = 1'b0;
        padv_wrbk_i      = 1'b0;
        pipeline_flush_i = 1'b0;
        dcod_rfd1_we_i   = 1'b0;
        dcod_rfd1_adr_i  = '0;
        dcod_rfd2_we_i   = 1'b0;
        dcod_rfd2_adr_i  = '0;
        model_reset();
        #12;
        check_reset_vals("reset");
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;

        // Single push of D1 r5, then fill to full.
        step("push_r5", 1, 0, 0, 1, 5'd5, 0, 5'd0);
        cmp("first.exec_extadr", 32'(exec_extadr_o), 0);
        cmp("first.adr1", 32'(exec_rfd1_adr_o), 5);
        cmp("first.dcod_extadr", 32'(dcod_extadr_o), 1);
        step("fill1", 1, 0, 0, 0, 5'd7, 1, 5'd9);
        step("fill2", 1, 0, 0, 1, 5'd3, 1, 5'd4);
        step("fill3", 1, 0, 0, 1, 5'd31, 0, 5'd1);
        cmp("full.flag", 32'(ordq_full_o), 1);
        step("push_full", 1, 0, 0, 1, 5'd11, 1, 5'd12);
        cmp("push_full.err", 32'(ordq_err_o), 32'(CHECK_EN));
        cmp("push_full.head", 32'(exec_extadr_o), 0);

        // Full queue, push and pop together: only the pop happens.
        step("full_pushpop", 1, 1, 0, 1, 5'd20, 1, 5'd21);
        cmp("full_pushpop.head", 32'(exec_extadr_o), 1);
        cmp("full_pushpop.notfull", 32'(ordq_full_o), 0);

        // Three in flight, flush alongside a push.
        step("flush", 1, 0, 1, 1, 5'd2, 1, 5'd2);
        cmp("flush.empty", 32'(ordq_empty_o), 1);
        cmp("flush.dcod", 32'(dcod_extadr_o), 0);
        cmp("flush.err", 32'(ordq_err_o), 0);

        // Keep one entry in flight across the ID wrap.
        step("wrap_fill", 1, 0, 0, 1, 5'd1, 0, 5'd0);
        for (int i = 0; i < 9; i++) begin
            cmp("wrap.head", 32'(exec_extadr_o), 32'(i % 8));
            cmp("wrap.notfull", 32'(ordq_full_o), 0);
            step("wrap", 1, 1, 0, 1, 5'(i), 1, 5'(i + 10));
        end
        step("drain", 0, 1, 0, 0, 5'd0, 0, 5'd0);
        step("pop_empty", 0, 1, 0, 0, 5'd0, 0, 5'd0);
        cmp("pop_empty.err", 32'(ordq_err_o), 32'(CHECK_EN));
        step("clear", 0, 0, 1, 0, 5'd0, 0, 5'd0);

        for (int i = 0; i < 400; i++) begin
            step("rand",
                 $urandom_range(0, 99) < 55,
                 $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 3,
                 1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom));
        end

        // Two entries in flight, asynchronous reset between edges.
        step("pre_rst", 0, 0, 1, 0, 5'd0, 0, 5'd0);
        step("pre_rst1", 1, 0, 0, 1, 5'd6, 1, 5'd7);
        step("pre_rst2", 1, 0, 0, 1, 5'd8, 1, 5'd9);
        padv_exec_i = 1'b0;
        cmp("pre_rst.valid", 32'(exec_valid_o), 1);
        #2;
        cpu_rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        model_reset();
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        step("post_rst", 1, 0, 0, 1, 5'd13, 0, 5'd0);
        step("post_rst_chk", 0, 0, 0, 0, 5'd0, 0, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
